// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared pipeline constants, sequencer state and forward-select helper
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_E     = 2'd1;
  localparam logic [1:0] FWD_M     = 2'd2;
  localparam logic [1:0] FWD_W     = 2'd3;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_e;

  // Youngest qualifying producer wins; W always has its result ready.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       e_allowed,
    input logic [4:0] a3_e,
    input logic [1:0] tnew_e,
    input logic [4:0] a3_m,
    input logic [1:0] tnew_m,
    input logic [4:0] a3_w
  );
    if (e_allowed && a3_e == src && a3_e != 5'd0 && tnew_e == 2'd0) return FWD_E;
    if (a3_m == src && a3_m != 5'd0 && tnew_m == 2'd0) return FWD_M;
    if (a3_w == src && a3_w != 5'd0) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_seq.sv
// rtl/hazard_ctrl_md_seq.sv - multiply/divide busy sequencer (IDLE/BUSY with down-counter)
module md_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start_E,
  input  logic md_is_div_E,
  output logic md_busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  md_state_e state, state_n;
  logic [CW-1:0] md_cnt, md_cnt_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= MD_IDLE;
      md_cnt <= '0;
    end else begin
      state  <= state_n;
      md_cnt <= md_cnt_n;
    end
  end

  // A start always reloads, so an unexpected start while BUSY restarts the count.
  always_comb begin
    state_n  = state;
    md_cnt_n = md_cnt;
    if (md_start_E) begin
      state_n  = MD_BUSY;
      md_cnt_n = md_is_div_E ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (state == MD_BUSY) begin
      if (md_cnt <= CW'(1)) begin
        state_n  = MD_IDLE;
        md_cnt_n = '0;
      end else begin
        md_cnt_n = md_cnt - CW'(1);
      end
    end
  end

  assign md_busy = (state == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/forwarding control and mult/div interlock
// Optional stall statistics counter enabled by HAZ_STATS_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  Tuse_rs_D,
  input  logic [1:0]  Tuse_rt_D,
  input  logic [4:0]  rs_E,
  input  logic [4:0]  rt_E,
  input  logic [4:0]  A3_E,
  input  logic [4:0]  A3_M,
  input  logic [4:0]  A3_W,
  input  logic [1:0]  Tnew_E,
  input  logic [1:0]  Tnew_M,
  input  logic        md_start_E,
  input  logic        md_is_div_E,
  input  logic        md_use_D,
  output logic        stall,
  output logic        flush_E,
  output logic [1:0]  fwd_rs_D,
  output logic [1:0]  fwd_rt_D,
  output logic [1:0]  fwd_rs_E,
  output logic [1:0]  fwd_rt_E,
`ifdef HAZ_STATS_EN
  output logic [31:0] stall_count,
`endif
  output logic        md_busy
);

  logic stall_rs_e, stall_rt_e, stall_rs_m, stall_rt_m;
  logic data_stall, md_stall;

  // A producer stalls D only when its result arrives later than D needs it.
  assign stall_rs_e = (rs_D == A3_E) && (A3_E != 5'd0) && (Tuse_rs_D < Tnew_E);
  assign stall_rt_e = (rt_D == A3_E) && (A3_E != 5'd0) && (Tuse_rt_D < Tnew_E);
  assign stall_rs_m = (rs_D == A3_M) && (A3_M != 5'd0) && (Tuse_rs_D < Tnew_M);
  assign stall_rt_m = (rt_D == A3_M) && (A3_M != 5'd0) && (Tuse_rt_D < Tnew_M);

  assign data_stall = stall_rs_e | stall_rt_e | stall_rs_m | stall_rt_m;
  assign md_stall   = md_use_D && (md_busy || md_start_E);
  assign stall      = data_stall | md_stall;
  assign flush_E    = stall;

  assign fwd_rs_D = fwd_sel(rs_D, 1'b1, A3_E, Tnew_E, A3_M, Tnew_M, A3_W);
  assign fwd_rt_D = fwd_sel(rt_D, 1'b1, A3_E, Tnew_E, A3_M, Tnew_M, A3_W);
  assign fwd_rs_E = fwd_sel(rs_E, 1'b0, A3_E, Tnew_E, A3_M, Tnew_M, A3_W);
  assign fwd_rt_E = fwd_sel(rt_E, 1'b0, A3_E, Tnew_E, A3_M, Tnew_M, A3_W);

  md_seq #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_seq (
    .clk        (clk),
    .reset      (reset),
    .md_start_E (md_start_E),
    .md_is_div_E(md_is_div_E),
    .md_busy    (md_busy)
  );

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && stall_count != 32'hFFFF_FFFF) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table-driven bench for hazard_ctrl plus mult/div sequences
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_D, rt_D, rs_E, rt_E, A3_E, A3_M, A3_W;
  logic [1:0]  Tuse_rs_D, Tuse_rt_D, Tnew_E, Tnew_M;
  logic        md_start_E, md_is_div_E, md_use_D;
  logic        stall, flush_E, md_busy;
  logic [1:0]  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
`ifdef HAZ_STATS_EN
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .rs_D       (rs_D),
    .rt_D       (rt_D),
    .Tuse_rs_D  (Tuse_rs_D),
    .Tuse_rt_D  (Tuse_rt_D),
    .rs_E       (rs_E),
    .rt_E       (rt_E),
    .A3_E       (A3_E),
    .A3_M       (A3_M),
    .A3_W       (A3_W),
    .Tnew_E     (Tnew_E),
    .Tnew_M     (Tnew_M),
    .md_start_E (md_start_E),
    .md_is_div_E(md_is_div_E),
    .md_use_D   (md_use_D),
    .stall      (stall),
    .flush_E    (flush_E),
    .fwd_rs_D   (fwd_rs_D),
    .fwd_rt_D   (fwd_rt_D),
    .fwd_rs_E   (fwd_rs_E),
    .fwd_rt_E   (fwd_rt_E),
`ifdef HAZ_STATS_EN
    .stall_count(stall_count),
`endif
    .md_busy    (md_busy)
  );

  typedef struct {
    string      name;
    logic [4:0] rs_d, rt_d;
    logic [1:0] tuse_rs, tuse_rt;
    logic [4:0] rs_e, rt_e, a3_e, a3_m, a3_w;
    logic [1:0] tnew_e, tnew_m;
    logic       exp_stall;
    logic [1:0] exp_rs_d, exp_rt_d, exp_rs_e, exp_rt_e;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rs_D = v.rs_d; rt_D = v.rt_d; Tuse_rs_D = v.tuse_rs; Tuse_rt_D = v.tuse_rt;
    rs_E = v.rs_e; rt_E = v.rt_e; A3_E = v.a3_e; A3_M = v.a3_m; A3_W = v.a3_w;
    Tnew_E = v.tnew_e; Tnew_M = v.tnew_m;
  endtask

  task automatic check_vec(input vec_t v);
    check({v.name, " stall"},    32'(stall),    32'(v.exp_stall));
    check({v.name, " flush_E"},  32'(flush_E),  32'(v.exp_stall));
    check({v.name, " fwd_rs_D"}, 32'(fwd_rs_D), 32'(v.exp_rs_d));
    check({v.name, " fwd_rt_D"}, 32'(fwd_rt_D), 32'(v.exp_rt_d));
    check({v.name, " fwd_rs_E"}, 32'(fwd_rs_E), 32'(v.exp_rs_e));
    check({v.name, " fwd_rt_E"}, 32'(fwd_rt_E), 32'(v.exp_rt_e));
  endtask

  // Advance one clock; mirror the statistics counter from the bench's own expected stall.
  task automatic tick(input logic exp_stall_now);
    @(posedge clk);
    if (reset) exp_cnt = 0;
    else if (exp_stall_now) exp_cnt++;
    #1;
  endtask

  initial begin
    //          name      rsD rtD tuRs tuRt rsE rtE A3E A3M A3W tnE tnM  stl rsD rtD rsE rtE
    vecs[0]  = '{"load_use",  8, 0, 1, 3,  0, 0, 8, 0, 0, 2, 0,  1, 0, 0, 0, 0};
    vecs[1]  = '{"m_stall",   8, 0, 0, 3,  0, 0, 0, 8, 0, 0, 1,  1, 0, 0, 0, 0};
    vecs[2]  = '{"w_fwd",     8, 0, 1, 3,  0, 0, 0, 0, 8, 0, 0,  0, 3, 0, 0, 0};
    vecs[3]  = '{"alu_fwd",   0, 0, 3, 3,  0, 5, 0, 5, 5, 0, 0,  0, 0, 0, 0, 2};
    vecs[4]  = '{"zero_reg",  0, 0, 0, 3,  0, 0, 0, 0, 0, 2, 0,  0, 0, 0, 0, 0};
    vecs[5]  = '{"e_prio",    3, 3, 0, 0,  3, 0, 3, 3, 3, 0, 0,  0, 1, 1, 2, 0};
    vecs[6]  = '{"m_fwd_d",   4, 0, 2, 3,  0, 0, 4, 4, 0, 1, 0,  0, 2, 0, 0, 0};
    vecs[7]  = '{"rt_m_stl",  0, 9, 3, 0,  0, 0, 0, 9, 0, 0, 1,  1, 0, 0, 0, 0};
    vecs[8]  = '{"tuse_none", 7, 0, 3, 3,  0, 0, 7, 0, 0, 2, 0,  0, 0, 0, 0, 0};
    vecs[9]  = '{"e_from_w", 12, 0, 3, 3, 12,12, 0,12,12, 0, 1,  0, 3, 0, 3, 3};
    vecs[10] = '{"m_ready",   8, 0, 1, 3,  0, 0, 0, 8, 0, 0, 1,  0, 0, 0, 0, 0};
    vecs[11] = '{"rt_e_stl",  0, 6, 3, 0,  0, 0, 6, 0, 0, 1, 0,  1, 0, 0, 0, 0};

    reset = 1'b1;
    md_start_E = 1'b0; md_is_div_E = 1'b0; md_use_D = 1'b0;
    drive(vecs[4]);
    tick(1'b0);
    tick(1'b0);
    @(negedge clk);
    check("reset md_busy", 32'(md_busy), 32'd0);
    check("reset idle stall", 32'(stall), 32'd0);
    drive(vecs[0]);
    @(negedge clk);
    check("stall during reset", 32'(stall), 32'd1);
`ifdef HAZ_STATS_EN
    check("reset stall_count", stall_count, 32'd0);
`endif
    tick(1'b1);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check_vec(vecs[i]);
      tick(vecs[i].exp_stall);
    end
    drive(vecs[4]);

    // Multiply with dependent mfhi in D: busy 5 cycles, stall 6 cycles.
    md_start_E = 1'b1; md_is_div_E = 1'b0; md_use_D = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) md_start_E = 1'b0;
      @(negedge clk);
      check($sformatf("mult busy c%0d", c), 32'(md_busy), 32'((c >= 1 && c <= 5) ? 1 : 0));
      check($sformatf("mult stall c%0d", c), 32'(stall), 32'((c <= 5) ? 1 : 0));
      tick(c <= 5);
    end

    // Full divide, no dependent instruction: busy for 10 cycles.
    md_start_E = 1'b1; md_is_div_E = 1'b1; md_use_D = 1'b0;
    for (int c = 0; c < 13; c++) begin
      if (c == 1) md_start_E = 1'b0;
      @(negedge clk);
      check($sformatf("div busy c%0d", c), 32'(md_busy), 32'((c >= 1 && c <= 10) ? 1 : 0));
      tick(1'b0);
    end

    // Restart while busy: a new multiply reloads the count.
    md_start_E = 1'b1; md_is_div_E = 1'b1;
    tick(1'b0);
    md_start_E = 1'b0;
    tick(1'b0);
    md_start_E = 1'b1; md_is_div_E = 1'b0;
    tick(1'b0);
    md_start_E = 1'b0;
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("reload busy c%0d", c), 32'(md_busy), 32'((c <= 5) ? 1 : 0));
      tick(1'b0);
    end

`ifdef HAZ_STATS_EN
    @(negedge clk);
    check("stall_count total", stall_count, 32'(exp_cnt));
`endif

    // Divide interrupted by reset on its 4th busy cycle.
    md_start_E = 1'b1; md_is_div_E = 1'b1; md_use_D = 1'b1;
    tick(1'b1);
    md_start_E = 1'b0; md_use_D = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) reset = 1'b1;
      @(negedge clk);
      check($sformatf("div pre-reset busy c%0d", c), 32'(md_busy), 32'd1);
      tick(1'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("div after reset busy", 32'(md_busy), 32'd0);
`ifdef HAZ_STATS_EN
    check("div after reset stall_count", stall_count, 32'd0);
`endif
    tick(1'b0);
    @(negedge clk);
    check("idle after reset busy", 32'(md_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
